// File: rtl/phase_scheduler.sv
// Four-approach traffic phase scheduler: round-robin arbitration, green extensions,
// yellow and all-red clearance, all sequenced through one shared external timer.
module phase_scheduler #(
  parameter int MAX_EXT = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       Expired,
  output logic       Start_Timer,
  output logic [1:0] Interval,
  output logic [3:0] Grant,
  output logic [3:0] Yellow,
  output logic       AllRed,
  output logic [3:0] Req_Clear,
  output logic [1:0] Phase
);

  typedef enum logic [2:0] {IDLE, GREEN, EXTEND, YELLOW, ALLRED} state_t;

  state_t     state_q;
  logic       start_q;
  logic [1:0] interval_q;
  logic [3:0] grant_q;
  logic [3:0] yellow_q;
  logic       allred_q;
  logic [3:0] clr_q;
  logic [1:0] phase_q;
  logic [1:0] ext_q;
  logic [1:0] rr_q;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic [3:0] phase_oh;
  logic       exp_ok;
  logic       only_mine;
  logic       ext_ok;

  // Circular search starting just after the last served approach.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k + 1);
      if (!win_vld && Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign phase_oh  = 4'b0001 << phase_q;
  assign exp_ok    = Expired && !start_q;
  assign only_mine = Req[phase_q] && ((Req & ~phase_oh) == '0);
  assign ext_ok    = int'(ext_q) < MAX_EXT;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      interval_q <= 2'b00;
      grant_q    <= '0;
      yellow_q   <= '0;
      allred_q   <= 1'b1;
      clr_q      <= '0;
      phase_q    <= 2'd0;
      ext_q      <= 2'd0;
      rr_q       <= 2'd3;
    end else begin
      start_q <= 1'b0;
      clr_q   <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_q    <= GREEN;
            grant_q    <= 4'b0001 << win_idx;
            clr_q      <= 4'b0001 << win_idx;
            phase_q    <= win_idx;
            rr_q       <= win_idx;
            start_q    <= 1'b1;
            interval_q <= 2'b00;
            ext_q      <= 2'd0;
            allred_q   <= 1'b0;
          end
        end
        GREEN, EXTEND: begin
          if (exp_ok) begin
            start_q <= 1'b1;
            if (only_mine && ext_ok) begin
              state_q    <= EXTEND;
              interval_q <= 2'b01;
              if (ext_q != 2'b11) ext_q <= ext_q + 2'd1;
            end else begin
              state_q    <= YELLOW;
              interval_q <= 2'b10;
              grant_q    <= '0;
              yellow_q   <= phase_oh;
            end
          end
        end
        YELLOW: begin
          if (exp_ok) begin
            state_q    <= ALLRED;
            interval_q <= 2'b11;
            yellow_q   <= '0;
            allred_q   <= 1'b1;
            start_q    <= 1'b1;
          end
        end
        ALLRED: begin
          if (exp_ok) begin
            interval_q <= 2'b00;
            if (win_vld) begin
              state_q  <= GREEN;
              grant_q  <= 4'b0001 << win_idx;
              clr_q    <= 4'b0001 << win_idx;
              phase_q  <= win_idx;
              rr_q     <= win_idx;
              start_q  <= 1'b1;
              ext_q    <= 2'd0;
              allred_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Start_Timer = start_q;
  assign Interval    = interval_q;
  assign Grant       = grant_q;
  assign Yellow      = yellow_q;
  assign AllRed      = allred_q;
  assign Req_Clear   = clr_q;
  assign Phase       = phase_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: reset, extensions, round-robin order,
// wrap-around arbitration, ignored Expired pulses and mid-phase reset.
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Req = '0;
  logic       Expired = 1'b0;
  logic       Start_Timer;
  logic [1:0] Interval;
  logic [3:0] Grant;
  logic [3:0] Yellow;
  logic       AllRed;
  logic [3:0] Req_Clear;
  logic [1:0] Phase;

  int n_assert = 0;
  int n_fail   = 0;

  phase_scheduler #(.MAX_EXT(2)) dut (
    .clk(clk), .Reset(Reset), .Req(Req), .Expired(Expired),
    .Start_Timer(Start_Timer), .Interval(Interval), .Grant(Grant),
    .Yellow(Yellow), .AllRed(AllRed), .Req_Clear(Req_Clear), .Phase(Phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    Expired = 1'b1;
    step();
    Expired = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".grant"},  Grant, 4'h0);
    check({tag, ".yellow"}, Yellow, 4'h0);
    check({tag, ".allred"}, {3'b0, AllRed}, 4'h1);
    check({tag, ".start"},  {3'b0, Start_Timer}, 4'h0);
    check({tag, ".intv"},   {2'b0, Interval}, 4'h0);
    check({tag, ".clr"},    Req_Clear, 4'h0);
    check({tag, ".phase"},  {2'b0, Phase}, 4'h0);
  endtask

  task automatic to_grant(input logic [1:0] idx);
    step();
    pulse();
    check("grant.grant",  Grant, 4'b0001 << idx);
    check("grant.phase",  {2'b0, Phase}, {2'b0, idx});
    check("grant.clr",    Req_Clear, 4'b0001 << idx);
    check("grant.start",  {3'b0, Start_Timer}, 4'h1);
    check("grant.intv",   {2'b0, Interval}, 4'h0);
    check("grant.allred", {3'b0, AllRed}, 4'h0);
  endtask

  task automatic to_yellow(input logic [1:0] idx);
    step();
    check("green.clr_once", Req_Clear, 4'h0);
    check("green.start_off", {3'b0, Start_Timer}, 4'h0);
    pulse();
    check("yellow.yellow", Yellow, 4'b0001 << idx);
    check("yellow.grant",  Grant, 4'h0);
    check("yellow.intv",   {2'b0, Interval}, 4'h2);
    check("yellow.start",  {3'b0, Start_Timer}, 4'h1);
  endtask

  task automatic to_allred();
    step();
    pulse();
    check("allred.allred", {3'b0, AllRed}, 4'h1);
    check("allred.yellow", Yellow, 4'h0);
    check("allred.grant",  Grant, 4'h0);
    check("allred.intv",   {2'b0, Interval}, 4'h3);
    check("allred.start",  {3'b0, Start_Timer}, 4'h1);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 Reset = 1'b1;
    #1 check_reset("rst_async");
    step();
    Reset = 1'b0;

    // IDLE holds with no requests, and ignores Expired
    step();
    check("idle.allred", {3'b0, AllRed}, 4'h1);
    check("idle.grant", Grant, 4'h0);
    pulse();
    check("idle_exp.grant", Grant, 4'h0);
    check("idle_exp.start", {3'b0, Start_Timer}, 4'h0);

    // First grant goes to approach 0
    Req = 4'b0001;
    step();
    check("g0.grant", Grant, 4'b0001);
    check("g0.start", {3'b0, Start_Timer}, 4'h1);
    check("g0.intv",  {2'b0, Interval}, 4'h0);
    check("g0.clr",   Req_Clear, 4'b0001);
    check("g0.phase", {2'b0, Phase}, 4'h0);

    // Expired during the Start_Timer cycle is ignored
    pulse();
    check("st_exp.grant", Grant, 4'b0001);
    check("st_exp.start", {3'b0, Start_Timer}, 4'h0);
    check("st_exp.intv",  {2'b0, Interval}, 4'h0);
    check("st_exp.clr",   Req_Clear, 4'h0);

    // Two extensions then yellow
    pulse();
    check("ext1.intv",  {2'b0, Interval}, 4'h1);
    check("ext1.start", {3'b0, Start_Timer}, 4'h1);
    check("ext1.grant", Grant, 4'b0001);
    step();
    pulse();
    check("ext2.intv",  {2'b0, Interval}, 4'h1);
    check("ext2.start", {3'b0, Start_Timer}, 4'h1);
    check("ext2.grant", Grant, 4'b0001);
    step();
    pulse();
    check("ext_sat.yellow", Yellow, 4'b0001);
    check("ext_sat.grant",  Grant, 4'h0);
    check("ext_sat.intv",   {2'b0, Interval}, 4'h2);

    // Round-robin with all requests held
    Req = 4'b1111;
    to_allred();
    to_grant(2'd1);
    to_yellow(2'd1);
    to_allred();
    to_grant(2'd2);
    to_yellow(2'd2);
    to_allred();
    to_grant(2'd3);
    to_yellow(2'd3);
    to_allred();
    to_grant(2'd0);

    // Serve 2, then wrap-around arbitration picks 0 over 2
    to_yellow(2'd0);
    to_allred();
    Req = 4'b0100;
    to_grant(2'd2);
    Req = 4'b0101;
    to_yellow(2'd2);
    to_allred();
    to_grant(2'd0);
    to_yellow(2'd0);
    to_allred();
    Req = 4'b0000;
    step();
    pulse();
    check("to_idle.allred", {3'b0, AllRed}, 4'h1);
    check("to_idle.grant",  Grant, 4'h0);
    check("to_idle.start",  {3'b0, Start_Timer}, 4'h0);
    check("to_idle.intv",   {2'b0, Interval}, 4'h0);
    step();
    check("idle2.grant", Grant, 4'h0);

    // Grant 1, reach yellow, then reset in the middle of the cycle
    Req = 4'b0011;
    step();
    check("g1.grant", Grant, 4'b0010);
    check("g1.phase", {2'b0, Phase}, 4'h1);
    to_yellow(2'd1);
    #2 Reset = 1'b1;
    #1 check_reset("rst_mid");
    Expired = 1'b1;
    step();
    Expired = 1'b0;
    check_reset("rst_held");
    Reset = 1'b0;
    Req = 4'b0010;
    #1;
    check("release.clr",   Req_Clear, 4'h0);
    check("release.start", {3'b0, Start_Timer}, 4'h0);
    step();
    check("post_rst.grant", Grant, 4'b0010);
    check("post_rst.phase", {2'b0, Phase}, 4'h1);
    check("post_rst.clr",   Req_Clear, 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
